// File: rtl/pwm_cap_pkg.sv
// Shared state encoding and default sizing for the PWM capture block.
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_t;

    localparam int          CNT_W_DEF       = 16;
    localparam logic [15:0] TIMEOUT_MAX_DEF = 16'd50000;
    localparam logic [3:0]  FILTER_LEN_DEF  = 4'd3;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Synchronizes pwm_i, optionally glitch-filters it (PWM_CAP_GLITCH_FILTER_EN), and detects edges.
// Latency: 2 cycles to level_o (+FILTER_LEN with filter); rise_o/fall_o are combinational on level_o.
// Backpressure: none; free-running sampler.
module pwm_capture_edge_sync #(
    parameter logic [3:0] FILTER_LEN = 4'd3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic       filt_q;
    logic       filt_d;
    logic [3:0] flt_cnt_q;
    logic [3:0] flt_cnt_d;

    // The filtered level flips only once the new value has been seen FILTER_LEN cycles in a row.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = 4'd0;
        if (sync2_q != filt_q) begin
            if (flt_cnt_q == FILTER_LEN - 4'd1) begin
                filt_d = sync2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt_q    <= 1'b0;
            flt_cnt_q <= 4'd0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign level = sync2_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period/high time in sys_clk cycles and flags a stuck input after TIMEOUT_MAX idle cycles.
// Latency: meas_valid 3 edges after pwm_in is first sampled high (+FILTER_LEN with filter).
// Backpressure: none; results are overwritten each PWM cycle.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_MAX_DEF),
    parameter logic [3:0]       FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             timeout_flag,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    logic level;
    logic rise;
    logic fall;

    pwm_capture_edge_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_edge_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pwm_i     (pwm_in),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    cap_state_t       state_q,      state_d;
    logic [CNT_W-1:0] cnt_period_q, cnt_period_d;
    logic [CNT_W-1:0] cnt_high_q,   cnt_high_d;
    logic [CNT_W-1:0] cnt_idle_q,   cnt_idle_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_q,       high_d;
    logic             timeout_q,    timeout_d;
    logic             stuck_q,      stuck_d;
    logic             edge_seen;
    logic             timeout_hit;

    always_comb begin
        state_d      = state_q;
        cnt_period_d = cnt_period_q;
        cnt_high_d   = cnt_high_q;
        cnt_idle_d   = cnt_idle_q;
        meas_valid_d = 1'b0;
        period_d     = period_q;
        high_d       = high_q;
        timeout_d    = timeout_q;
        stuck_d      = stuck_q;

        edge_seen = rise | fall;
        // An edge in the same cycle suppresses the timeout, so a late rise still yields a measurement.
        timeout_hit = !edge_seen && (cnt_idle_q == TIMEOUT_MAX - ONE);

        if (edge_seen) begin
            cnt_idle_d = ZERO;
        end else if (cnt_idle_q != TIMEOUT_MAX) begin
            cnt_idle_d = cnt_idle_q + ONE;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_period_d = ZERO;
                cnt_high_d   = ZERO;
                if (rise) begin
                    state_d      = ST_HIGH;
                    cnt_period_d = ONE;
                    cnt_high_d   = ONE;
                end
            end
            ST_HIGH: begin
                cnt_period_d = cnt_period_q + ONE;
                if (fall) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_high_d = cnt_high_q + ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    meas_valid_d = 1'b1;
                    period_d     = cnt_period_q;
                    high_d       = cnt_high_q;
                    timeout_d    = 1'b0;
                    state_d      = ST_HIGH;
                    cnt_period_d = ONE;
                    cnt_high_d   = ONE;
                end else begin
                    cnt_period_d = cnt_period_q + ONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_period_d = ZERO;
                cnt_high_d   = ZERO;
            end
        endcase

        if (timeout_hit) begin
            state_d      = ST_IDLE;
            cnt_period_d = ZERO;
            cnt_high_d   = ZERO;
            if (!timeout_q) begin
                timeout_d = 1'b1;
                stuck_d   = level;
                period_d  = ZERO;
                high_d    = ZERO;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_period_q <= ZERO;
            cnt_high_q   <= ZERO;
            cnt_idle_q   <= ZERO;
            meas_valid_q <= 1'b0;
            period_q     <= ZERO;
            high_q       <= ZERO;
            timeout_q    <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_period_q <= cnt_period_d;
            cnt_high_q   <= cnt_high_d;
            cnt_idle_q   <= cnt_idle_d;
            meas_valid_q <= meas_valid_d;
            period_q     <= period_d;
            high_q       <= high_d;
            timeout_q    <= timeout_d;
            stuck_q      <= stuck_d;
        end
    end

    assign meas_valid   = meas_valid_q;
    assign period_out   = period_q;
    assign high_out     = high_q;
    assign timeout_flag = timeout_q;
    assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT_MAX = 100.
module tb_pwm_capture;

    localparam int CNT_W = 16;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int LAT   = 5;
    localparam int EXP3_P = 80;
    localparam int EXP3_H = 20;
`else
    localparam int LAT   = 2;
    localparam int EXP3_P = 32;
    localparam int EXP3_H = 1;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b1;
    logic             pwm_in = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             timeout_flag;
    logic             stuck_level;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT_MAX (16'd100),
        .FILTER_LEN  (4'd3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pwm_in       (pwm_in),
        .meas_valid   (meas_valid),
        .period_out   (period_out),
        .high_out     (high_out),
        .timeout_flag (timeout_flag),
        .stuck_level  (stuck_level)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int last_valid_idx = -1;
    logic last_to = 1'b1;
    int exp_p = 0;
    int exp_h = 0;
    int saved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive lvl for n cycles; every meas_valid pulse is checked against exp_p/exp_h.
    task automatic step(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = lvl;
            @(posedge sys_clk);
            #1;
            if (meas_valid === 1'b1) begin
                n_valid++;
                last_valid_idx = i;
                last_to = timeout_flag;
                check("valid_period", {16'd0, period_out}, exp_p);
                check("valid_high", {16'd0, high_out}, exp_h);
            end
        end
    endtask

    initial begin
        #2 sys_rst_n = 1'b0;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
        end
        check("rst_valid", {31'd0, meas_valid}, 0);
        check("rst_period", {16'd0, period_out}, 0);
        check("rst_high", {16'd0, high_out}, 0);
        check("rst_timeout", {31'd0, timeout_flag}, 0);
        check("rst_stuck", {31'd0, stuck_level}, 0);
        sys_rst_n = 1'b1;

        // 10 high / 40 low, 5 periods
        exp_p = 50;
        exp_h = 10;
        step(1'b1, 10);
        step(1'b0, 40);
        check("t1_no_first_valid", n_valid, 0);
        last_valid_idx = -1;
        step(1'b1, 10);
        check("t1_latency", last_valid_idx, LAT);
        step(1'b0, 40);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 10);
            step(1'b0, 40);
        end
        check("t1_valid_count", n_valid, 4);
        check("t1_no_timeout", {31'd0, timeout_flag}, 0);
        check("t1_period_held", {16'd0, period_out}, 50);

        // Asynchronous reset in the middle of a LOW phase
        sys_rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, meas_valid}, 0);
        check("arst_period", {16'd0, period_out}, 0);
        check("arst_high", {16'd0, high_out}, 0);
        check("arst_timeout", {31'd0, timeout_flag}, 0);
        check("arst_stuck", {31'd0, stuck_level}, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        n_valid = 0;

`ifdef PWM_CAP_GLITCH_FILTER_EN
        // 20/30 with a 2-cycle low glitch in each high phase
        exp_p = 50;
        exp_h = 20;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 9);
            step(1'b0, 2);
            step(1'b1, 9);
            step(1'b0, 30);
        end
        step(1'b0, 30);
        check("t2_valid_count", n_valid, 2);
`else
        // 1 high / 1 low toggling, 8 rises
        exp_p = 2;
        exp_h = 1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1);
            step(1'b0, 1);
        end
        step(1'b0, 30);
        check("t2_valid_count", n_valid, 7);
`endif

        // One more measurement, then hold high into timeout
        exp_p = EXP3_P;
        exp_h = EXP3_H;
        saved = n_valid;
        last_valid_idx = -1;
        step(1'b1, LAT + 1);
        check("t3_meas_idx", last_valid_idx, LAT);
        check("t3_meas_count", n_valid, saved + 1);
        step(1'b1, 99);
        check("t3_no_timeout_yet", {31'd0, timeout_flag}, 0);
        step(1'b1, 1);
        check("t3_timeout", {31'd0, timeout_flag}, 1);
        check("t3_stuck", {31'd0, stuck_level}, 1);
        check("t3_period_zero", {16'd0, period_out}, 0);
        check("t3_high_zero", {16'd0, high_out}, 0);
        check("t3_no_valid", n_valid, saved + 1);
        step(1'b1, 20);
        check("t3_flag_held", {31'd0, timeout_flag}, 1);

        // Resume 20/30 after the timeout
        exp_p = 50;
        exp_h = 20;
        saved = n_valid;
        step(1'b0, 30);
        step(1'b1, 20);
        step(1'b0, 30);
        check("t4_no_first_valid", n_valid, saved);
        check("t4_flag_still_set", {31'd0, timeout_flag}, 1);
        step(1'b1, 20);
        check("t4_valid_count", n_valid, saved + 1);
        check("t4_flag_clear_at_valid", {31'd0, last_to}, 0);
        check("t4_flag_clear", {31'd0, timeout_flag}, 0);
        step(1'b0, 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
